tl_arbiter: RTL

TL_ARBITER -- requirements
Module: tl_arbiter

---
 rtl/tl_arbiter_if.sv | 40 ++++
 rtl/tl_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_arbiter_if.sv
// TileLink-UL channel bundle (A request, D response) shared by arbiter ports.
// Latency: none, wires only.
// Backpressure: valid/ready on both channels; master drives A, slave drives D.
interface tilelink;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_arbiter.sv
// Two-to-one TL-UL arbiter, one outstanding single-beat transaction, round-robin on ties.
// Latency: request seen in IDLE reaches s.a one cycle later; D channel is a combinational pass-through.
// Backpressure: s.a_ready/m.d_ready pass straight through to the granted side; optional D watchdog via TL_ARB_TIMEOUT_EN.
module tl_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic    clk,
    input  logic    rst,
    tilelink.slave  m0,
    tilelink.slave  m1,
    tilelink.master s
);

`ifdef TL_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, AREQ, DRESP, DERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, AREQ, DRESP} state_t;
`endif

    state_t      state, state_nxt;
    logic        grant, grant_nxt;
    logic        rr_prio, rr_prio_nxt;
    logic [2:0]  lat_opcode, lat_size;
    logic [3:0]  lat_source;

    logic        req_valid, req_corrupt;
    logic [2:0]  req_opcode, req_param, req_size;
    logic [3:0]  req_source;
    logic [31:0] req_address;
    logic [7:0]  req_mask;
    logic [63:0] req_data;

    logic        rsp_valid, rsp_ready, rsp_sink, rsp_denied, rsp_corrupt;
    logic [2:0]  rsp_opcode, rsp_size;
    logic [1:0]  rsp_param;
    logic [3:0]  rsp_source;
    logic [63:0] rsp_data;

    logic        sel_d_ready;
    logic        a_fire, d_fire;

    // Granted master's A channel, forced to zero whenever not in AREQ
    always_comb begin
        req_valid   = 1'b0;
        req_opcode  = '0;
        req_param   = '0;
        req_size    = '0;
        req_source  = '0;
        req_address = '0;
        req_mask    = '0;
        req_data    = '0;
        req_corrupt = 1'b0;
        if (state == AREQ) begin
            req_valid   = grant ? m1.a_valid   : m0.a_valid;
            req_opcode  = grant ? m1.a_opcode  : m0.a_opcode;
            req_param   = grant ? m1.a_param   : m0.a_param;
            req_size    = grant ? m1.a_size    : m0.a_size;
            req_source  = grant ? m1.a_source  : m0.a_source;
            req_address = grant ? m1.a_address : m0.a_address;
            req_mask    = grant ? m1.a_mask    : m0.a_mask;
            req_data    = grant ? m1.a_data    : m0.a_data;
            req_corrupt = grant ? m1.a_corrupt : m0.a_corrupt;
        end
    end

    assign s.a_valid   = req_valid;
    assign s.a_opcode  = req_opcode;
    assign s.a_param   = req_param;
    assign s.a_size    = req_size;
    assign s.a_source  = req_source;
    assign s.a_address = req_address;
    assign s.a_mask    = req_mask;
    assign s.a_data    = req_data;
    assign s.a_corrupt = req_corrupt;

    assign m0.a_ready  = (state == AREQ) && !grant && s.a_ready;
    assign m1.a_ready  = (state == AREQ) &&  grant && s.a_ready;
    assign a_fire      = req_valid && s.a_ready;
    assign sel_d_ready = grant ? m1.d_ready : m0.d_ready;

    // D channel toward the masters: slave pass-through in DRESP, synthesized error in DERR
    always_comb begin
        rsp_valid   = 1'b0;
        rsp_ready   = 1'b0;
        rsp_opcode  = '0;
        rsp_param   = '0;
        rsp_size    = '0;
        rsp_source  = '0;
        rsp_sink    = 1'b0;
        rsp_denied  = 1'b0;
        rsp_data    = '0;
        rsp_corrupt = 1'b0;
        case (state)
            DRESP: begin
                rsp_valid   = s.d_valid;
                rsp_ready   = sel_d_ready;
                rsp_opcode  = s.d_opcode;
                rsp_param   = s.d_param;
                rsp_size    = s.d_size;
                rsp_source  = s.d_source;
                rsp_sink    = s.d_sink;
                rsp_denied  = s.d_denied;
                rsp_data    = s.d_data;
                rsp_corrupt = s.d_corrupt;
            end
`ifdef TL_ARB_TIMEOUT_EN
            DERR: begin
                // Get expects AccessAckData; every other opcode gets a plain AccessAck
                rsp_valid  = 1'b1;
                rsp_denied = 1'b1;
                rsp_source = lat_source;
                rsp_size   = lat_size;
                rsp_opcode = (lat_opcode == 3'd4) ? 3'd1 : 3'd0;
            end
`endif
            default: ;
        endcase
    end

    assign s.d_ready   = rsp_ready;
    assign d_fire      = s.d_valid && rsp_ready;

    assign m0.d_valid  = rsp_valid && !grant;
    assign m1.d_valid  = rsp_valid &&  grant;
    assign m0.d_opcode = rsp_opcode;
    assign m1.d_opcode = rsp_opcode;
    assign m0.d_param  = rsp_param;
    assign m1.d_param  = rsp_param;
    assign m0.d_size   = rsp_size;
    assign m1.d_size   = rsp_size;
    assign m0.d_source = rsp_source;
    assign m1.d_source = rsp_source;
    assign m0.d_sink   = rsp_sink;
    assign m1.d_sink   = rsp_sink;
    assign m0.d_denied = rsp_denied;
    assign m1.d_denied = rsp_denied;
    assign m0.d_data   = rsp_data;
    assign m1.d_data   = rsp_data;
    assign m0.d_corrupt = rsp_corrupt;
    assign m1.d_corrupt = rsp_corrupt;

`ifdef TL_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    // Expire in the cycle the count would step to TIMEOUT_CYCLES-1
    assign wd_expire = !s.d_valid && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 2));

    // Watchdog: idle at zero outside DRESP, counts DRESP cycles with no slave response
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (state != DRESP)
            wd_cnt <= '0;
        else if (!s.d_valid)
            wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{lat_opcode, lat_size, lat_source, (TIMEOUT_CYCLES > 0)};
`endif

    // Next-state, grant selection and round-robin update
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_prio_nxt = rr_prio;
        case (state)
            IDLE: begin
                if (m0.a_valid && m1.a_valid) begin
                    grant_nxt = rr_prio;
                    state_nxt = AREQ;
                end else if (m0.a_valid) begin
                    grant_nxt = 1'b0;
                    state_nxt = AREQ;
                end else if (m1.a_valid) begin
                    grant_nxt = 1'b1;
                    state_nxt = AREQ;
                end
            end
            AREQ: begin
                if (a_fire)
                    state_nxt = DRESP;
            end
            DRESP: begin
                if (d_fire) begin
                    state_nxt   = IDLE;
                    rr_prio_nxt = ~grant;
                end
`ifdef TL_ARB_TIMEOUT_EN
                else if (wd_expire)
                    state_nxt = DERR;
`endif
            end
`ifdef TL_ARB_TIMEOUT_EN
            DERR: begin
                if (sel_d_ready) begin
                    state_nxt   = IDLE;
                    rr_prio_nxt = ~grant;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant and request-field capture; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            rr_prio    <= 1'b0;
            lat_opcode <= '0;
            lat_size   <= '0;
            lat_source <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_prio <= rr_prio_nxt;
            if (a_fire) begin
                lat_opcode <= req_opcode;
                lat_size   <= req_size;
                lat_source <= req_source;
            end
        end
    end

endmodule
